// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART frame decoder: FSM states, default sync byte, error codes.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer; built only when UART_FRAME_TIMEOUT_EN is defined.
`ifdef UART_FRAME_TIMEOUT_EN
module uart_gap_timer #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Counter holds the number of idle cycles since the last byte, saturating at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule
`endif

// File: rtl/uart_frame_decoder.sv
// Decodes SYNC/CMD/LEN/payload/CHK frames from a UART byte stream into buffer writes.
// Optional inter-byte timeout is enabled with UART_FRAME_TIMEOUT_EN.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = 4
`ifdef UART_FRAME_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 20000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        frame_cmd,
  output logic [7:0]        frame_len,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_cmd;
  logic [7:0]      r_len;
  logic [7:0]      r_chk;
  logic [ADDR_W:0] r_cnt;
  logic            w_done;
  logic            w_err;
  logic [1:0]      w_code;
  logic            w_wr;
  logic            w_last;
  logic            w_tmo;
  logic            w_take;

`ifdef UART_FRAME_TIMEOUT_EN
  uart_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (r_state != ST_IDLE),
    .i_clear  (rx_valid),
    .o_expire (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  // A byte arriving together with a timeout is dropped.
  assign w_take = rx_valid && !w_tmo;
  assign w_last = (9'(r_cnt) == ({1'b0, r_len} - 9'd1));
  assign w_wr   = w_take && (r_state == ST_PAYLOAD);

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_code      = ERR_LEN;
    if (w_tmo) begin
      w_state_nxt = ST_IDLE;
      w_err       = 1'b1;
      w_code      = ERR_TMO;
    end else if (rx_valid) begin
      case (r_state)
        ST_IDLE: if (rx_data == SYNC_BYTE) w_state_nxt = ST_CMD;
        ST_CMD:  w_state_nxt = ST_LEN;
        ST_LEN: begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
            w_code      = ERR_LEN;
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: if (w_last) w_state_nxt = ST_CHK;
        ST_CHK: begin
          w_state_nxt = ST_IDLE;
          if (rx_data == r_chk) begin
            w_done = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_code = ERR_CHK;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_len      <= '0;
      r_chk      <= '0;
      r_cnt      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_cmd  <= '0;
      frame_len  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      busy       <= (w_state_nxt != ST_IDLE);
      wr_en      <= w_wr;
      frame_done <= w_done;
      frame_err  <= w_err;
      if (w_err) err_code <= w_code;
      if (w_done) begin
        frame_cmd <= r_cmd;
        frame_len <= r_len;
      end
      if (w_take) begin
        case (r_state)
          ST_CMD: begin
            r_cmd <= rx_data;
            r_chk <= rx_data;
          end
          ST_LEN: begin
            r_len <= rx_data;
            r_chk <= r_chk ^ rx_data;
            r_cnt <= '0;
          end
          ST_PAYLOAD: begin
            wr_addr <= r_cnt[ADDR_W-1:0];
            wr_data <= rx_data;
            r_chk   <= r_chk ^ rx_data;
            r_cnt   <= r_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign dbg_state = r_state;

endmodule
